mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM: drives the control inputs of Data_path_more from the fetched instruction.

---
 rtl/mc_ctrl_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset control FSM, 3-5 cycles per instruction plus memory wait cycles; mem_req held until mem_ready.
// Defining MC_CTRL_TRAP_EN adds a one-cycle TRAP state for undefined ops and add/sub/addi overflow.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRW,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] Branch,
    output logic [2:0] ALU_Control,
    output logic       ALUSrc_B,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] DatatoReg,
    output logic       Jal,
    output logic [3:0] state,
    output logic       mem_err,
    output logic       trap
);
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A;
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IF  = 4'h0,
        S_ID  = 4'h1,
        S_EXR = 4'h2,
        S_EXI = 4'h3,
        S_MA  = 4'h4,
        S_MR  = 4'h5,
        S_MW  = 4'h6,
        S_WB  = 4'h7,
        S_BR  = 4'h8,
        S_JMP = 4'h9,
        S_JR  = 4'hA
`ifdef MC_CTRL_TRAP_EN
        , S_TRAP = 4'hF
`endif
    } state_t;

    state_t        st;
    logic [CW-1:0] wait_cnt;
    logic          drop;
    logic          err_q;
    logic          r_alu, i_alu, is_r, arith, ovf_kill, mem_wait, expire;
    logic [2:0]    fun_ctl, imm_ctl;

    always_comb begin
        r_alu   = 1'b1;
        fun_ctl = 3'b010;
        case (Fun)
            F_ADD:   fun_ctl = 3'b010;
            F_SUB:   fun_ctl = 3'b110;
            F_AND:   fun_ctl = 3'b000;
            F_OR:    fun_ctl = 3'b001;
            F_NOR:   fun_ctl = 3'b100;
            F_SLT:   fun_ctl = 3'b111;
            F_SRL:   fun_ctl = 3'b101;
            default: r_alu   = 1'b0;
        endcase
        i_alu   = 1'b1;
        imm_ctl = 3'b010;
        case (OPcode)
            OP_ADDI: imm_ctl = 3'b010;
            OP_ANDI: imm_ctl = 3'b000;
            OP_ORI:  imm_ctl = 3'b001;
            OP_SLTI: imm_ctl = 3'b111;
            default: i_alu   = 1'b0;
        endcase
    end

    assign is_r     = (OPcode == OP_R);
    assign arith    = (is_r && (Fun == F_ADD || Fun == F_SUB)) || (OPcode == OP_ADDI);
    assign ovf_kill = arith && overflow;
    // The cycle after a timeout is spent idle in IF so mem_req visibly drops.
    assign mem_wait = (st == S_IF && !drop) || st == S_MR || st == S_MW;
    assign expire   = (MEM_TIMEOUT > 0) && mem_wait && !mem_ready &&
                      (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IF;
            wait_cnt <= '0;
            drop     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (mem_wait && !mem_ready && !expire) wait_cnt <= wait_cnt + 1'b1;
            else                                   wait_cnt <= '0;
            if (expire) begin
                err_q <= 1'b1;
                drop  <= 1'b1;
                st    <= S_IF;
            end else begin
                case (st)
                    S_IF: if (!drop && mem_ready) st <= S_ID;
                    S_ID: begin
                        if (is_r && r_alu)              st <= S_EXR;
                        else if (is_r && Fun == F_JR)   st <= S_JR;
                        else if (i_alu)                 st <= S_EXI;
                        else begin
                            case (OPcode)
                                OP_LUI:         st <= S_WB;
                                OP_LW, OP_SW:   st <= S_MA;
                                OP_BEQ, OP_BNE: st <= S_BR;
                                OP_J, OP_JAL:   st <= S_JMP;
`ifdef MC_CTRL_TRAP_EN
                                default:        st <= S_TRAP;
`else
                                default:        st <= S_IF;
`endif
                            endcase
                        end
                    end
`ifdef MC_CTRL_TRAP_EN
                    S_EXR, S_EXI: st <= ovf_kill ? S_TRAP : S_WB;
`else
                    S_EXR, S_EXI: st <= S_WB;
`endif
                    S_MA: st <= (OPcode == OP_SW) ? S_MW : S_MR;
                    S_MR: if (mem_ready) st <= S_WB;
                    S_MW: if (mem_ready) st <= S_IF;
                    default: st <= S_IF;
                endcase
            end
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        MemRW       = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 2'b00;
        ALU_Control = 3'b000;
        ALUSrc_B    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        DatatoReg   = 2'b00;
        Jal         = 1'b0;
        trap        = 1'b0;
        if (!rst) begin
            case (st)
                S_IF: if (!drop) begin
                    mem_req = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_EXR: ALU_Control = fun_ctl;
                S_EXI: begin
                    ALUSrc_B    = 1'b1;
                    ALU_Control = imm_ctl;
                end
                S_MA: begin
                    ALUSrc_B    = 1'b1;
                    ALU_Control = 3'b010;
                end
                S_MR, S_MW: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    MemRW   = (st == S_MW);
                end
                S_WB: begin
                    RegWrite  = !ovf_kill;
                    RegDst    = is_r;
                    DatatoReg = (OPcode == OP_LW) ? 2'b01 : (OPcode == OP_LUI) ? 2'b10 : 2'b00;
                end
                S_BR: begin
                    ALU_Control = 3'b110;
                    PCWrite     = (OPcode == OP_BNE) ? !zero : zero;
                    Branch      = 2'b01;
                end
                S_JMP: begin
                    PCWrite = 1'b1;
                    Branch  = 2'b10;
                    if (OPcode == OP_JAL) begin
                        RegWrite  = 1'b1;
                        Jal       = 1'b1;
                        DatatoReg = 2'b11;
                    end
                end
                S_JR: begin
                    PCWrite = 1'b1;
                    Branch  = 2'b11;
                end
`ifdef MC_CTRL_TRAP_EN
                S_TRAP: trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign state   = st;
    assign mem_err = err_q && !rst;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm: an instruction-level model emits per-cycle stimulus and expected outputs.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst, zero, overflow, mem_ready;
    logic [5:0] OPcode, Fun;
    logic       mem_req, MemRW, IorD, IRWrite, PCWrite, ALUSrc_B, RegWrite, RegDst, Jal, mem_err, trap;
    logic [1:0] Branch, DatatoReg;
    logic [2:0] ALU_Control;
    logic [3:0] state;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero), .overflow(overflow),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemRW(MemRW), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .ALU_Control(ALU_Control), .ALUSrc_B(ALUSrc_B),
        .RegWrite(RegWrite), .RegDst(RegDst), .DatatoReg(DatatoReg), .Jal(Jal), .state(state),
        .mem_err(mem_err), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, MemRW, IorD, IRWrite, PCWrite;
        logic [1:0] Branch;
        logic [2:0] alu;
        logic       ALUSrc_B, RegWrite, RegDst;
        logic [1:0] DatatoReg;
        logic       Jal, mem_err, trap;
    } outv_t;

    typedef enum {K_RALU, K_IALU, K_JR, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_BAD} kind_t;
    typedef struct {
        string      name;
        logic [5:0] op, fun;
        kind_t      kind;
        logic [2:0] alu;
        bit         arith;
    } ins_t;

    ins_t       tbl[$];
    outv_t      sb[$];
    string      tags[$];
    int         n_checks = 0, n_fail = 0, budget = -1;
    bit         merr = 1'b0;
    logic [5:0] cur_op = '0, cur_fun = '0;
    logic       cur_zero = 1'b0, cur_ov = 1'b0;
    string      cur_tag = "";

    task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn,
                       input kind_t k, input logic [2:0] alu, input bit ar);
        ins_t t;
        t.name = n; t.op = op; t.fun = fn; t.kind = k; t.alu = alu; t.arith = ar;
        tbl.push_back(t);
    endtask

    function automatic int idx_of(input string n);
        foreach (tbl[i]) if (tbl[i].name == n) return i;
        return 0;
    endfunction

    function automatic outv_t base();
        outv_t e = '0;
        e.mem_err = merr;
        return e;
    endfunction

    function automatic int rand_wait();
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // One clock cycle of stimulus plus the response it must produce.
    task automatic emit(input logic rdy, input outv_t e);
        if (budget == 0) return;
        if (budget > 0) budget--;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = rdy; OPcode = cur_op; Fun = cur_fun;
        zero = cur_zero; overflow = cur_ov;
        sb.push_back(e); tags.push_back(cur_tag);
    endtask

    task automatic emit_any(input outv_t e);
        emit(1'($urandom_range(0, 1)), e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; mem_ready = 1'($urandom_range(0, 1));
            sb.push_back('0); tags.push_back("reset");
        end
        merr = 1'b0;
    endtask

    // w wait cycles then mem_ready; at TMO or more waits the request times out.
    task automatic mem_phase(input int w, input outv_t req, input outv_t fin, output bit ok);
        int n = (w < TMO) ? w : TMO;
        for (int i = 0; i < n; i++) emit(1'b0, req);
        if (w >= TMO) begin
            merr = 1'b1;
            emit_any(base());
            ok = 1'b0;
        end else begin
            emit(1'b1, fin);
            ok = 1'b1;
        end
    endtask

    task automatic run_instr(input int idx, input int wf, input int wm, input logic z, input logic ov);
        ins_t  t = tbl[idx];
        outv_t e, f;
        bit    ok;
        cur_op = t.op; cur_fun = (t.op == 6'h00) ? t.fun : 6'($urandom);
        cur_zero = z; cur_ov = ov; cur_tag = t.name;
        e = base(); e.mem_req = 1'b1;
        f = e; f.IRWrite = 1'b1; f.PCWrite = 1'b1;
        mem_phase(wf, e, f, ok);
        if (!ok) return;
        emit_any(base());
        e = base();
        case (t.kind)
            K_RALU, K_IALU: begin
                e.alu = t.alu; e.ALUSrc_B = (t.kind == K_IALU);
                emit_any(e);
`ifdef MC_CTRL_TRAP_EN
                if (t.arith && ov) begin
                    e = base(); e.trap = 1'b1; emit_any(e);
                    return;
                end
`endif
                e = base(); e.RegWrite = !(t.arith && ov); e.RegDst = (t.kind == K_RALU);
                emit_any(e);
            end
            K_LUI: begin
                e.RegWrite = 1'b1; e.DatatoReg = 2'b10; emit_any(e);
            end
            K_LW, K_SW: begin
                e.ALUSrc_B = 1'b1; e.alu = 3'b010; emit_any(e);
                e = base(); e.mem_req = 1'b1; e.IorD = 1'b1; e.MemRW = (t.kind == K_SW);
                mem_phase(wm, e, e, ok);
                if (ok && t.kind == K_LW) begin
                    e = base(); e.RegWrite = 1'b1; e.DatatoReg = 2'b01; emit_any(e);
                end
            end
            K_BEQ, K_BNE: begin
                e.alu = 3'b110; e.Branch = 2'b01;
                e.PCWrite = (t.kind == K_BEQ) ? z : !z;
                emit_any(e);
            end
            K_J, K_JAL: begin
                e.PCWrite = 1'b1; e.Branch = 2'b10;
                if (t.kind == K_JAL) begin
                    e.RegWrite = 1'b1; e.Jal = 1'b1; e.DatatoReg = 2'b11;
                end
                emit_any(e);
            end
            K_JR: begin
                e.PCWrite = 1'b1; e.Branch = 2'b11; emit_any(e);
            end
            default: begin
`ifdef MC_CTRL_TRAP_EN
                e.trap = 1'b1; emit_any(e);
`endif
            end
        endcase
    endtask

    outv_t act, want;
    string tg;
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                want = sb.pop_front();
                tg   = tags.pop_front();
                act.mem_req = mem_req; act.MemRW = MemRW; act.IorD = IorD; act.IRWrite = IRWrite;
                act.PCWrite = PCWrite; act.Branch = Branch; act.alu = ALU_Control;
                act.ALUSrc_B = ALUSrc_B; act.RegWrite = RegWrite; act.RegDst = RegDst;
                act.DatatoReg = DatatoReg; act.Jal = Jal; act.mem_err = mem_err; act.trap = trap;
                n_checks++;
                if (act !== want) begin
                    n_fail++;
                    $display("FAIL %s @%0t: outputs got %h required %h", tg, $time, act, want);
                end
                if (!rst) begin
                    n_checks++;
                    if ((state == 4'hF) !== want.trap) begin
                        n_fail++;
                        $display("FAIL %s_trapstate @%0t: state %h, trap expected %b", tg, $time, state, want.trap);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; OPcode = '0; Fun = '0; zero = 1'b0; overflow = 1'b0;
        add("add",  6'h00, 6'h20, K_RALU, 3'b010, 1'b1);
        add("sub",  6'h00, 6'h22, K_RALU, 3'b110, 1'b1);
        add("and",  6'h00, 6'h24, K_RALU, 3'b000, 1'b0);
        add("or",   6'h00, 6'h25, K_RALU, 3'b001, 1'b0);
        add("nor",  6'h00, 6'h27, K_RALU, 3'b100, 1'b0);
        add("slt",  6'h00, 6'h2A, K_RALU, 3'b111, 1'b0);
        add("srl",  6'h00, 6'h02, K_RALU, 3'b101, 1'b0);
        add("jr",   6'h00, 6'h08, K_JR,   3'b000, 1'b0);
        add("addi", 6'h08, 6'h00, K_IALU, 3'b010, 1'b1);
        add("andi", 6'h0C, 6'h00, K_IALU, 3'b000, 1'b0);
        add("ori",  6'h0D, 6'h00, K_IALU, 3'b001, 1'b0);
        add("slti", 6'h0A, 6'h00, K_IALU, 3'b111, 1'b0);
        add("lui",  6'h0F, 6'h00, K_LUI,  3'b000, 1'b0);
        add("lw",   6'h23, 6'h00, K_LW,   3'b000, 1'b0);
        add("sw",   6'h2B, 6'h00, K_SW,   3'b000, 1'b0);
        add("beq",  6'h04, 6'h00, K_BEQ,  3'b000, 1'b0);
        add("bne",  6'h05, 6'h00, K_BNE,  3'b000, 1'b0);
        add("j",    6'h02, 6'h00, K_J,    3'b000, 1'b0);
        add("jal",  6'h03, 6'h00, K_JAL,  3'b000, 1'b0);
        add("badR", 6'h00, 6'h01, K_BAD,  3'b000, 1'b0);
        add("badO", 6'h3F, 6'h20, K_BAD,  3'b000, 1'b0);

        do_reset(2);
        run_instr(idx_of("nor"), 0, 0, 1'b0, 1'b0);
        run_instr(idx_of("lw"),  0, 3, 1'b0, 1'b0);
        run_instr(idx_of("beq"), 0, 0, 1'b1, 1'b0);
        run_instr(idx_of("beq"), 0, 0, 1'b0, 1'b0);
        run_instr(idx_of("jal"), 0, 0, 1'b0, 1'b0);
        run_instr(idx_of("add"), 0, 0, 1'b0, 1'b1);
        run_instr(idx_of("badO"), 1, 0, 1'b0, 1'b0);

        repeat (300) run_instr(int'($urandom_range(0, tbl.size() - 1)), rand_wait(), rand_wait(),
                               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

        // Reset while lw is waiting in its data read.
        budget = 4;
        run_instr(idx_of("lw"), 0, 3, 1'b0, 1'b0);
        budget = -1;
        do_reset(1);
        run_instr(idx_of("addi"), 0, 0, 1'b0, 1'b0);

        run_instr(idx_of("add"), 5, 0, 1'b0, 1'b0);
        run_instr(idx_of("lw"),  0, TMO, 1'b0, 1'b0);
        run_instr(idx_of("sw"),  2, 7, 1'b0, 1'b0);
        repeat (20) run_instr(int'($urandom_range(0, tbl.size() - 1)), rand_wait(), rand_wait(),
                              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        do_reset(2);
        repeat (5) run_instr(int'($urandom_range(0, tbl.size() - 1)), rand_wait(), rand_wait(),
                             1'($urandom_range(0, 1)), 1'b0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
